// File: rtl/nettlp_reset_seq.sv
// Cold-reset and staged bring-up sequencer for the NetTLP adapter: holds all
// domains in reset, releases them one by one, then supervises PCIe link-up.
module nettlp_reset_seq #(
    parameter int                   NUM_DOMAINS       = 4,
    parameter int                   CNT_WIDTH         = 14,
    parameter logic [CNT_WIDTH-1:0] COLD_RESET_INTVAL = 14'hfff,
    parameter int                   STAGE_GAP         = 16,
    parameter int                   LINK_TIMEOUT      = 4096,
    parameter int                   RETRY_WIDTH       = 4
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   soft_rst_req,
    input  logic                   link_up,
    output logic [NUM_DOMAINS-1:0] rst_n_out,
    output logic [1:0]             seq_state,
    output logic                   ready,
    output logic [RETRY_WIDTH-1:0] retry_cnt
);

    typedef enum logic [1:0] {
        ST_COLD      = 2'd0,
        ST_RELEASE   = 2'd1,
        ST_WAIT_LINK = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    // One shared phase counter, wide enough for the longest phase.
    localparam int REL_LEN   = NUM_DOMAINS * STAGE_GAP;
    localparam int PHASE_MAX = (REL_LEN > LINK_TIMEOUT) ? REL_LEN : LINK_TIMEOUT;
    localparam int PW        = $clog2(PHASE_MAX + 1);
    localparam int TW        = (CNT_WIDTH > PW) ? CNT_WIDTH : PW;

    localparam int              COLD_LAST_I = int'(COLD_RESET_INTVAL) - 1;
    localparam logic [TW-1:0]   COLD_LAST   = TW'(COLD_LAST_I);
    localparam logic [TW-1:0]   REL_LAST    = TW'(REL_LEN - 1);
    localparam logic [TW-1:0]   LINK_LAST   = TW'(LINK_TIMEOUT - 1);
    localparam logic [RETRY_WIDTH-1:0] RETRY_MAX = {RETRY_WIDTH{1'b1}};

    state_t                   state_r, state_nxt_s;
    logic [TW-1:0]            cnt_r, cnt_nxt_s;
    logic [NUM_DOMAINS-1:0]   rst_n_out_r, rst_n_out_nxt_s;
    logic                     ready_r;
    logic [RETRY_WIDTH-1:0]   retry_r, retry_nxt_s;
    logic                     retry_inc_s;
    logic                     link_meta_r, link_sync_r;

    // Domains whose release slot has been reached by RELEASE cycle k.
    function automatic logic [NUM_DOMAINS-1:0] release_mask(input logic [TW-1:0] k);
        release_mask = {NUM_DOMAINS{1'b0}};
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            release_mask[i] = (TW'(i * STAGE_GAP) <= k);
        end
    endfunction

    // Next-state and phase counter; a software request overrides every state.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        retry_inc_s = 1'b0;
        if (soft_rst_req) begin
            state_nxt_s = ST_COLD;
            cnt_nxt_s   = {TW{1'b0}};
        end else begin
            case (state_r)
                ST_COLD: begin
                    if (cnt_r == COLD_LAST) begin
                        state_nxt_s = ST_RELEASE;
                        cnt_nxt_s   = {TW{1'b0}};
                    end else begin
                        cnt_nxt_s = cnt_r + TW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt_r == REL_LAST) begin
                        state_nxt_s = ST_WAIT_LINK;
                        cnt_nxt_s   = {TW{1'b0}};
                    end else begin
                        cnt_nxt_s = cnt_r + TW'(1);
                    end
                end
                ST_WAIT_LINK: begin
                    // Link-up in the timeout cycle still goes to RUN.
                    if (link_sync_r) begin
                        state_nxt_s = ST_RUN;
                        cnt_nxt_s   = {TW{1'b0}};
                    end else if (cnt_r == LINK_LAST) begin
                        state_nxt_s = ST_COLD;
                        cnt_nxt_s   = {TW{1'b0}};
                        retry_inc_s = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r + TW'(1);
                    end
                end
                ST_RUN: begin
                    // RUN is only entered with link_sync high, so low here is a drop.
                    if (!link_sync_r) begin
                        state_nxt_s = ST_COLD;
                        cnt_nxt_s   = {TW{1'b0}};
                        retry_inc_s = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end
                default: begin
                    state_nxt_s = ST_COLD;
                    cnt_nxt_s   = {TW{1'b0}};
                end
            endcase
        end
    end

    // Per-domain reset targets and saturating retry count for the next cycle.
    always_comb begin
        rst_n_out_nxt_s = {NUM_DOMAINS{1'b0}};
        case (state_nxt_s)
            ST_COLD:      rst_n_out_nxt_s = {NUM_DOMAINS{1'b0}};
            ST_RELEASE:   rst_n_out_nxt_s = rst_n_out_r | release_mask(cnt_nxt_s);
            ST_WAIT_LINK: rst_n_out_nxt_s = {NUM_DOMAINS{1'b1}};
            ST_RUN:       rst_n_out_nxt_s = {NUM_DOMAINS{1'b1}};
            default:      rst_n_out_nxt_s = {NUM_DOMAINS{1'b0}};
        endcase
        if (retry_inc_s && (retry_r != RETRY_MAX)) begin
            retry_nxt_s = retry_r + RETRY_WIDTH'(1);
        end else begin
            retry_nxt_s = retry_r;
        end
    end

    // Sequencer state, counters, registered outputs and link_up synchroniser.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r     <= ST_COLD;
            cnt_r       <= {TW{1'b0}};
            rst_n_out_r <= {NUM_DOMAINS{1'b0}};
            ready_r     <= 1'b0;
            retry_r     <= {RETRY_WIDTH{1'b0}};
            link_meta_r <= 1'b0;
            link_sync_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            rst_n_out_r <= rst_n_out_nxt_s;
            ready_r     <= (state_nxt_s == ST_RUN);
            retry_r     <= retry_nxt_s;
            link_meta_r <= link_up;
            link_sync_r <= link_meta_r;
        end
    end

    assign rst_n_out = rst_n_out_r;
    assign seq_state = state_r;
    assign ready     = ready_r;
    assign retry_cnt = retry_r;

endmodule

// File: tb/tb_nettlp_reset_seq.sv
// Directed bench for nettlp_reset_seq with a short configuration
// (COLD=8, STAGE_GAP=4, NUM_DOMAINS=3, LINK_TIMEOUT=20).
module tb_nettlp_reset_seq;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       soft_rst_req;
    logic       link_up;
    logic [2:0] rst_n_out;
    logic [1:0] seq_state;
    logic       ready;
    logic [3:0] retry_cnt;

    int errors;
    int checks;
    int cyc;

    nettlp_reset_seq #(
        .NUM_DOMAINS       (3),
        .CNT_WIDTH         (14),
        .COLD_RESET_INTVAL (14'd8),
        .STAGE_GAP         (4),
        .LINK_TIMEOUT      (20),
        .RETRY_WIDTH       (4)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .soft_rst_req (soft_rst_req),
        .link_up      (link_up),
        .rst_n_out    (rst_n_out),
        .seq_state    (seq_state),
        .ready        (ready),
        .retry_cnt    (retry_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Advance to the given cycle; samples and drives happen 1 time unit after the edge.
    task automatic go_to(input int target);
        while (cyc < target) begin
            @(posedge sys_clk);
            #1;
            cyc++;
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] e_rst, input logic [1:0] e_st,
                           input logic e_rdy, input logic [3:0] e_retry);
        chk({tag, ".rst_n_out"}, 32'(rst_n_out), 32'(e_rst));
        chk({tag, ".seq_state"}, 32'(seq_state), 32'(e_st));
        chk({tag, ".ready"},     32'(ready),     32'(e_rdy));
        chk({tag, ".retry_cnt"}, 32'(retry_cnt), 32'(e_retry));
    endtask

    // Assert reset mid-cycle, check it acts without a clock edge, then release.
    task automatic do_reset(input string tag);
        @(posedge sys_clk);
        #3;
        sys_rst_n    = 1'b0;
        soft_rst_req = 1'b0;
        link_up      = 1'b0;
        #1;
        chk_all(tag, 3'b000, 2'd0, 1'b0, 4'd0);
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        cyc       = 0;
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        cyc          = 0;
        sys_rst_n    = 1'b0;
        soft_rst_req = 1'b0;
        link_up      = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;

        // Staged release and link timeout with retry saturation
        chk_all("t1_c0", 3'b000, 2'd0, 1'b0, 4'd0);
        go_to(7);   chk_all("t1_c7",  3'b000, 2'd0, 1'b0, 4'd0);
        go_to(8);   chk_all("t1_c8",  3'b001, 2'd1, 1'b0, 4'd0);
        go_to(11);  chk("t1_c11", 32'(rst_n_out), 32'(3'b001));
        go_to(12);  chk("t1_c12", 32'(rst_n_out), 32'(3'b011));
        go_to(15);  chk("t1_c15", 32'(rst_n_out), 32'(3'b011));
        go_to(16);  chk("t1_c16", 32'(rst_n_out), 32'(3'b111));
        go_to(19);  chk_all("t1_c19", 3'b111, 2'd1, 1'b0, 4'd0);
        go_to(20);  chk_all("t1_c20", 3'b111, 2'd2, 1'b0, 4'd0);
        go_to(39);  chk_all("t2_c39", 3'b111, 2'd2, 1'b0, 4'd0);
        go_to(40);  chk_all("t2_c40", 3'b000, 2'd0, 1'b0, 4'd1);
        go_to(48);  chk_all("t2_c48", 3'b001, 2'd1, 1'b0, 4'd1);
        go_to(560); chk("t2_retry14", 32'(retry_cnt), 32'd14);
        go_to(600); chk_all("t2_c600", 3'b000, 2'd0, 1'b0, 4'd15);
        go_to(640); chk_all("t2_sat", 3'b000, 2'd0, 1'b0, 4'd15);

        // Link-up latency and link drop
        do_reset("t3_rst");
        go_to(25);  link_up = 1'b1;
        go_to(27);  chk_all("t3_c27", 3'b111, 2'd2, 1'b0, 4'd0);
        go_to(28);  chk_all("t3_c28", 3'b111, 2'd3, 1'b1, 4'd0);
        go_to(50);  link_up = 1'b0;
        go_to(52);  chk_all("t3_c52", 3'b111, 2'd3, 1'b1, 4'd0);
        go_to(53);  chk_all("t3_c53", 3'b000, 2'd0, 1'b0, 4'd1);

        // One-cycle soft reset pulse during RELEASE
        do_reset("t4_rst");
        go_to(13);  chk_all("t4_c13", 3'b011, 2'd1, 1'b0, 4'd0);
        soft_rst_req = 1'b1;
        go_to(14);  soft_rst_req = 1'b0;
        chk_all("t4_c14", 3'b000, 2'd0, 1'b0, 4'd0);
        go_to(21);  chk_all("t4_c21", 3'b000, 2'd0, 1'b0, 4'd0);
        go_to(22);  chk_all("t4_c22", 3'b001, 2'd1, 1'b0, 4'd0);

        // Soft reset held as a level for 30 cycles
        go_to(30);  soft_rst_req = 1'b1;
        go_to(31);  chk_all("t5_c31", 3'b000, 2'd0, 1'b0, 4'd0);
        go_to(45);  chk_all("t5_c45", 3'b000, 2'd0, 1'b0, 4'd0);
        go_to(60);  soft_rst_req = 1'b0;
        chk_all("t5_c60", 3'b000, 2'd0, 1'b0, 4'd0);
        go_to(67);  chk_all("t5_c67", 3'b000, 2'd0, 1'b0, 4'd0);
        go_to(68);  chk_all("t5_c68", 3'b001, 2'd1, 1'b0, 4'd0);

        // Link arrives in the timeout cycle, then async reset mid-RUN
        do_reset("t6_rst");
        go_to(37);  link_up = 1'b1;
        go_to(38);  chk_all("t6_c38", 3'b111, 2'd2, 1'b0, 4'd0);
        go_to(39);  chk_all("t6_c39", 3'b111, 2'd2, 1'b0, 4'd0);
        go_to(40);  chk_all("t6_c40", 3'b111, 2'd3, 1'b1, 4'd0);
        go_to(45);  chk_all("t6_c45", 3'b111, 2'd3, 1'b1, 4'd0);
        do_reset("t6_async");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
